mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the 4:1 single-bit multiplexer between four requesters.
- Drives the mux select lines (address0, address1) and a one-hot grant back to the requesters.
- Caps each tenure at HOLD_MAX cycles to prevent starvation.
- Sits directly in front of the structural/behavioural 4:1 mux; the mux data path is untouched.

---
 rtl/mux_arb_pkg.sv | 17 +
 rtl/rr_pick4.sv | 27 ++
 rtl/mux_rr_arbiter.sv | 95 +++++++++
 tb/tb_mux_rr_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and constants for the 4-way mux round-robin arbiter
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational first-hit search over 4 requests from a rotating start
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   start,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] w_cand;

  // Walk the order backwards so the earliest hit in search order is the last written.
  always_comb begin
    found  = 1'b0;
    idx    = start;
    w_cand = start;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = start + SEL_W'(k);
      if (req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin owner selection for the shared 4:1 mux with tenure cap
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               address0,
  output logic               address1,
  output logic               busy,
  output logic               expired
);

  arb_state_e         r_state;
  logic [SEL_W-1:0]   r_owner;
  logic [SEL_W-1:0]   r_last;
  logic [CNT_W-1:0]   r_count;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_expired;

  logic [SEL_W-1:0]   w_start;
  logic [SEL_W-1:0]   w_idx;
  logic               w_found;
  logic               w_owner_req;
  logic               w_at_cap;
  logic               w_release;

  assign w_owner_req = req[r_owner];
  assign w_at_cap    = (r_count >= CNT_W'(HOLD_MAX));
  assign w_release   = !w_owner_req || w_at_cap;

  // On release the outgoing owner is searched last, so it only wins when nobody else waits.
  assign w_start = (r_state == OWN) ? (r_owner + SEL_W'(1)) : (r_last + SEL_W'(1));

  rr_pick4 u_pick (
    .req   (req),
    .start (w_start),
    .found (w_found),
    .idx   (w_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_last    <= SEL_W'(NUM_REQ - 1);
      r_count   <= '0;
      r_grant   <= '0;
      r_expired <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable && w_found) begin
            r_state <= OWN;
            r_owner <= w_idx;
            r_grant <= onehot(w_idx);
            r_count <= CNT_W'(1);
          end
        end
        OWN: begin
          if (!w_release) begin
            r_count <= r_count + CNT_W'(1);
          end else begin
            r_last    <= r_owner;
            r_expired <= w_owner_req;
            if (enable && w_found) begin
              r_owner <= w_idx;
              r_grant <= onehot(w_idx);
              r_count <= CNT_W'(1);
            end else begin
              r_state <= IDLE;
              r_grant <= '0;
              r_count <= '0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // r_owner is left untouched on entry to IDLE so the select lines keep the last owner.
  assign grant    = r_grant;
  assign address0 = r_owner[0];
  assign address1 = r_owner[1];
  assign busy     = (r_state == OWN);
  assign expired  = r_expired;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed plus random checks of two arbiter instances against a reference model
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] req = 4'b0000;

  logic [3:0] g8, g1;
  logic       a80, a81, a10, a11;
  logic       b8, b1, e8, e1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.HOLD_MAX(8), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .grant(g8), .address0(a80), .address1(a81), .busy(b8), .expired(e8)
  );

  mux_rr_arbiter #(.HOLD_MAX(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .grant(g1), .address0(a10), .address1(a11), .busy(b1), .expired(e1)
  );

  typedef struct {
    bit own;
    int owner;
    int last;
    int cnt;
    bit exp;
  } mdl_t;

  mdl_t m8, m1;

  function automatic mdl_t mreset();
    mdl_t s;
    s.own = 0; s.owner = 0; s.last = 3; s.cnt = 0; s.exp = 0;
    return s;
  endfunction

  function automatic int first_in_order(input logic [3:0] r, input int from);
    for (int k = 0; k < 4; k++)
      if (r[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  function automatic mdl_t mstep(input mdl_t s, input logic [3:0] r, input logic en, input int hold);
    mdl_t n;
    int   w;
    n = s;
    n.exp = 0;
    if (!s.own) begin
      w = first_in_order(r, (s.last + 1) % 4);
      if (en && w >= 0) begin
        n.own = 1; n.owner = w; n.cnt = 1;
      end
    end else if (r[s.owner] && s.cnt < hold) begin
      n.cnt = s.cnt + 1;
    end else begin
      n.last = s.owner;
      n.exp  = r[s.owner];
      w = first_in_order(r, (s.owner + 1) % 4);
      if (en && w >= 0) begin
        n.owner = w; n.cnt = 1;
      end else begin
        n.own = 0; n.cnt = 0;
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] mgrant(input mdl_t s);
    return s.own ? (4'b0001 << s.owner) : 4'b0000;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/grant8"},   {4'b0, g8},        {4'b0, mgrant(m8)});
    check({tag, "/addr8"},    {6'b0, a81, a80},  8'(m8.owner));
    check({tag, "/busy8"},    {7'b0, b8},        {7'b0, m8.own});
    check({tag, "/expired8"}, {7'b0, e8},        {7'b0, m8.exp});
    check({tag, "/grant1"},   {4'b0, g1},        {4'b0, mgrant(m1)});
    check({tag, "/addr1"},    {6'b0, a11, a10},  8'(m1.owner));
    check({tag, "/busy1"},    {7'b0, b1},        {7'b0, m1.own});
    check({tag, "/expired1"}, {7'b0, e1},        {7'b0, m1.exp});
  endtask

  task automatic cycle(input string tag, input logic [3:0] r, input logic en);
    req = r;
    enable = en;
    @(posedge clk);
    m8 = mstep(m8, r, en, 8);
    m1 = mstep(m1, r, en, 1);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset(input logic [3:0] r);
    reset = 1'b1;
    req = r;
    #1;
    m8 = mreset();
    m1 = mreset();
    check_all("reset");
    check("reset_grant", {4'b0, g8}, 8'h00);
    check("reset_busy", {7'b0, b8}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] rr;
    logic       en;
    logic [3:0] e_g;
    int         n_exp;
    int         n_drop;

    m8 = mreset();
    m1 = mreset();
    @(negedge clk);
    do_reset(4'b0000);

    // single requester, grant latency and voluntary release
    cycle("tp1_idle", 4'b0000, 1'b1);
    cycle("tp1_req", 4'b0001, 1'b1);
    check("tp1_grant", {4'b0, g8}, 8'h01);
    check("tp1_addr", {6'b0, a81, a80}, 8'h00);
    check("tp1_busy", {7'b0, b8}, 8'h01);
    cycle("tp1_hold", 4'b0001, 1'b1);
    cycle("tp1_hold", 4'b0001, 1'b1);
    cycle("tp1_drop", 4'b0000, 1'b1);
    check("tp1_grant_off", {4'b0, g8}, 8'h00);
    check("tp1_busy_off", {7'b0, b8}, 8'h00);

    // enable gating: owner 1 releases while disabled, then 3 wins after re-enable
    cycle("en_grant", 4'b0010, 1'b1);
    check("en_owner1", {4'b0, g8}, 8'h02);
    cycle("en_hold", 4'b0010, 1'b0);
    check("en_hold_owner1", {4'b0, g8}, 8'h02);
    cycle("en_release", 4'b1001, 1'b0);
    check("en_idle_grant", {4'b0, g8}, 8'h00);
    check("en_idle_busy", {7'b0, b8}, 8'h00);
    cycle("en_reenable", 4'b1001, 1'b1);
    check("en_owner3", {4'b0, g8}, 8'h08);
    cycle("en_drop", 4'b0000, 1'b1);

    // all four requesting: rotation with 8-cycle tenures and no idle gap
    cycle("rot_start", 4'b1111, 1'b1);
    for (int h = 0; h < 4; h++) begin
      check("rot_owner", {4'b0, g8}, 8'(4'b0001 << h));
      for (int k = 0; k < 7; k++) begin
        cycle("rot_hold", 4'b1111, 1'b1);
        check("rot_no_expire", {7'b0, e8}, 8'h00);
      end
      cycle("rot_handoff", 4'b1111, 1'b1);
      check("rot_expired", {7'b0, e8}, 8'h01);
      check("rot_next", {4'b0, g8}, 8'(4'b0001 << ((h + 1) % 4)));
    end
    cycle("rot_drop", 4'b0000, 1'b1);

    // lone persistent requester 2 is regranted after each forced release
    n_exp = 0;
    n_drop = 0;
    for (int k = 0; k < 20; k++) begin
      cycle("solo", 4'b0100, 1'b1);
      if (e8) n_exp++;
      if (g8 !== 4'b0100) n_drop++;
    end
    check("solo_expired_count", 8'(n_exp), 8'd2);
    check("solo_grant_drops", 8'(n_drop), 8'd0);
    cycle("solo_drop", 4'b0000, 1'b1);

    // asynchronous reset mid-tenure, then restart from requester 0
    cycle("mid_grant", 4'b0100, 1'b1);
    check("mid_owner2", {4'b0, g8}, 8'h04);
    do_reset(4'b0110);
    cycle("mid_after", 4'b0110, 1'b1);
    check("mid_first_grant", {4'b0, g8}, 8'h02);
    check("mid_first_grant1", {4'b0, g1}, 8'h02);

    // HOLD_MAX=1: two requesters alternate every cycle with expired pulsing
    do_reset(4'b0000);
    cycle("h1_first", 4'b0011, 1'b1);
    e_g = 4'b0001;
    check("h1_first_grant", {4'b0, g1}, {4'b0, e_g});
    for (int k = 0; k < 8; k++) begin
      cycle("h1_alt", 4'b0011, 1'b1);
      e_g = (e_g == 4'b0001) ? 4'b0010 : 4'b0001;
      check("h1_alt_grant", {4'b0, g1}, {4'b0, e_g});
      check("h1_expired", {7'b0, e1}, 8'h01);
    end
    cycle("h1_drop", 4'b0000, 1'b1);

    // randomized traffic with sticky requests and occasional disable
    rr = 4'b0000;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 7) != 0);
      cycle("rand", rr, en);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
